hex_led_scan: RTL and testbench



---
 rtl/hex_led_scan.sv | 161 ++++++++++++++++
 tb/tb_hex_led_scan.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hex_led_scan.sv
`default_nettype none
// ============================================================================
// Module : hex_led_scan
// Multiplexed N-digit hex 7-segment driver with frame-synchronous shadow update,
// decimal points, leading-zero blanking and anti-ghosting dead time.
// Rev    : 1.0
// ============================================================================
module hex_led_scan #(
    parameter int DIGITS         = 4,
    parameter int CLK_DIV        = 50000,
    parameter int DEAD           = 2,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   dp_in,
    input  logic                load,
    input  logic                lz_blank,
    input  logic                enable,
    output logic [6:0]          symbol,
    output logic                dp,
    output logic [DIGITS-1:0]   digit,
    output logic                frame
);

    localparam int c_cnt_w  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int c_slot_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [c_cnt_w-1:0]  c_cnt_last  = c_cnt_w'(CLK_DIV - 1);
    localparam logic [c_cnt_w-1:0]  c_dead      = c_cnt_w'(DEAD);
    localparam logic [c_slot_w-1:0] c_slot_last = c_slot_w'(DIGITS - 1);

    localparam logic              c_seg_low = (SEG_ACTIVE_LOW != 0);
    localparam logic              c_dig_low = (DIG_ACTIVE_LOW != 0);
    localparam logic [6:0]        c_seg_off = {7{c_seg_low}};
    localparam logic [6:0]        c_seg_inv = {7{~c_seg_low}};
    localparam logic [DIGITS-1:0] c_dig_off = {DIGITS{c_dig_low}};

    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_slot_w-1:0] r_slot;
    logic [4*DIGITS-1:0] r_shadow_val;
    logic [DIGITS-1:0]   r_shadow_dp;
    logic [4*DIGITS-1:0] r_disp_val;
    logic [DIGITS-1:0]   r_disp_dp;
    logic                r_pending;
    logic [6:0]          r_symbol;
    logic                r_dp;
    logic [DIGITS-1:0]   r_digit;
    logic                r_frame;

    logic                w_cnt_wrap;
    logic                w_boundary;
    logic                w_dark;
    logic                w_upper_zero;
    logic                w_blank;
    logic [3:0]          w_nibble;

    // Segment pattern in active-low abcdefg form.
    function automatic logic [6:0] seg_code(input logic [3:0] n);
        logic [6:0] s;
        s = 7'b1111111;
        case (n)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            4'hF: s = 7'b0111000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        w_cnt_wrap = (r_cnt == c_cnt_last);
        w_boundary = w_cnt_wrap && (r_slot == c_slot_last);
        w_dark     = !enable || ((DEAD != 0) && (r_cnt < c_dead));
        w_nibble   = r_disp_val[4*int'(r_slot) +: 4];
        // A digit is a leading zero when it and every digit to its left are zero.
        w_upper_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if ((i >= int'(r_slot)) && (r_disp_val[4*i +: 4] != 4'h0)) begin
                w_upper_zero = 1'b0;
            end
        end
        w_blank = lz_blank && (r_slot != '0) && w_upper_zero;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_slot <= '0;
        end else if (w_cnt_wrap) begin
            r_cnt  <= '0;
            r_slot <= w_boundary ? '0 : r_slot + 1'b1;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    // A load in the boundary cycle overrides the shadow and still clears pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
            r_disp_val   <= '0;
            r_disp_dp    <= '0;
            r_pending    <= 1'b0;
        end else begin
            if (load) begin
                r_shadow_val <= value;
                r_shadow_dp  <= dp_in;
                r_pending    <= 1'b1;
            end
            if (w_boundary && (r_pending || load)) begin
                r_disp_val <= load ? value : r_shadow_val;
                r_disp_dp  <= load ? dp_in : r_shadow_dp;
                r_pending  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_symbol <= c_seg_off;
            r_dp     <= c_seg_low;
            r_digit  <= c_dig_off;
            r_frame  <= 1'b0;
        end else begin
            r_frame <= w_boundary;
            if (w_dark) begin
                r_symbol <= c_seg_off;
                r_dp     <= c_seg_low;
                r_digit  <= c_dig_off;
            end else begin
                r_symbol <= w_blank ? c_seg_off : (seg_code(w_nibble) ^ c_seg_inv);
                r_dp     <= r_disp_dp[r_slot] ^ c_seg_low;
                r_digit  <= (DIGITS'(1) << r_slot) ^ c_dig_off;
            end
        end
    end

    assign symbol = r_symbol;
    assign dp     = r_dp;
    assign digit  = r_digit;
    assign frame  = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_hex_led_scan.sv
`default_nettype none
// ============================================================================
// Module : tb_hex_led_scan
// Self-checking bench: vector table, hand sequences and random traffic vs model.
// Rev    : 1.0
// ============================================================================
module tb_hex_led_scan;

    localparam int DIGITS  = 4;
    localparam int CLK_DIV = 4;
    localparam int DEAD    = 1;
    localparam int FRAME   = DIGITS * CLK_DIV;

    localparam logic [6:0] SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        lz_blank = 1'b0;
    logic        enable = 1'b1;
    logic [6:0]  symbol;
    logic        dp;
    logic [3:0]  digit;
    logic        frame;

    int total = 0;
    int bad   = 0;

    hex_led_scan #(
        .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .DEAD(DEAD),
        .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
        .lz_blank(lz_blank), .enable(enable), .symbol(symbol), .dp(dp),
        .digit(digit), .frame(frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: position in the scan is derived from cycles since reset.
    int unsigned t_m;
    bit          started = 1'b0;
    logic [15:0] sh_v, disp_v;
    logic [3:0]  sh_d, disp_d;
    logic        pend;
    logic [3:0]  e_dig;
    logic [6:0]  e_sym;
    logic        e_dp, e_frame;

    function automatic int slot_of(input int unsigned t);
        return int'((t / CLK_DIV) % DIGITS);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            started <= 1'b1;
            t_m <= 0; sh_v <= '0; sh_d <= '0; disp_v <= '0; disp_d <= '0; pend <= 1'b0;
            e_dig <= 4'hF; e_sym <= 7'h7F; e_dp <= 1'b1; e_frame <= 1'b0;
        end else begin
            e_frame <= (t_m % FRAME) == FRAME - 1;
            if ((t_m % CLK_DIV) < DEAD || !enable) begin
                e_dig <= 4'hF; e_sym <= 7'h7F; e_dp <= 1'b1;
            end else begin
                e_dig <= ~(4'b0001 << slot_of(t_m));
                e_dp  <= ~disp_d[slot_of(t_m)];
                if (lz_blank && slot_of(t_m) != 0 && (disp_v >> (4 * slot_of(t_m))) == 16'h0)
                    e_sym <= 7'h7F;
                else
                    e_sym <= SEG[4'((disp_v >> (4 * slot_of(t_m))) & 16'hF)];
            end
            if (load) begin
                sh_v <= value; sh_d <= dp_in; pend <= 1'b1;
            end
            if ((t_m % FRAME) == FRAME - 1 && (pend || load)) begin
                disp_v <= load ? value : sh_v;
                disp_d <= load ? dp_in : sh_d;
                pend   <= 1'b0;
            end
            t_m <= t_m + 1;
        end
    end

    always @(negedge clk) begin
        if (started)
            chk("model", {19'd0, digit, symbol, dp, frame}, {19'd0, e_dig, e_sym, e_dp, e_frame});
    end

    typedef struct {
        logic [15:0] v;
        logic [3:0]  d;
        logic        lz;
        int          slot;
        logic [6:0]  sym;
        logic [3:0]  dig;
        logic        dpo;
    } vec_t;

    vec_t vecs[$];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v; dp_in = d; load = 1'b1;
        tick(1);
        load = 1'b0;
    endtask

    task automatic wait_frame();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3 * FRAME && !seen; i++) begin
            if (frame) seen = 1'b1;
            else tick(1);
        end
        if (!seen) begin
            bad++;
            total++;
            $display("FAIL frame_timeout: got no frame pulse expected one within %0d cycles", 3 * FRAME);
        end
    endtask

    initial begin
        vecs.push_back('{16'h12AF, 4'b0100, 1'b0, 0, 7'b0111000, 4'b1110, 1'b1});
        vecs.push_back('{16'h12AF, 4'b0100, 1'b0, 1, 7'b0001000, 4'b1101, 1'b1});
        vecs.push_back('{16'h12AF, 4'b0100, 1'b0, 2, 7'b0010010, 4'b1011, 1'b0});
        vecs.push_back('{16'h12AF, 4'b0100, 1'b0, 3, 7'b1001111, 4'b0111, 1'b1});
        vecs.push_back('{16'h0030, 4'b0000, 1'b1, 3, 7'b1111111, 4'b0111, 1'b1});
        vecs.push_back('{16'h0030, 4'b0000, 1'b1, 2, 7'b1111111, 4'b1011, 1'b1});
        vecs.push_back('{16'h0030, 4'b0000, 1'b1, 1, 7'b0000110, 4'b1101, 1'b1});
        vecs.push_back('{16'h0030, 4'b0000, 1'b1, 0, 7'b0000001, 4'b1110, 1'b1});
        vecs.push_back('{16'h0000, 4'b0000, 1'b1, 0, 7'b0000001, 4'b1110, 1'b1});
        vecs.push_back('{16'h0000, 4'b0000, 1'b1, 2, 7'b1111111, 4'b1011, 1'b1});
        vecs.push_back('{16'h0000, 4'b0000, 1'b0, 3, 7'b0000001, 4'b0111, 1'b1});
        vecs.push_back('{16'h0800, 4'b1000, 1'b1, 3, 7'b1111111, 4'b0111, 1'b0});

        tick(3);
        rst = 1'b0;
        tick(7);

        // Reset asserted mid-scan
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("reset_outputs", {22'd0, digit, symbol, dp, frame}, {22'd0, 4'b1111, 7'b1111111, 1'b1, 1'b0});
        end
        rst = 1'b0;
        tick(1);
        chk("post_reset_dead", {28'd0, digit}, {28'd0, 4'b1111});
        tick(1);
        chk("post_reset_slot0", {21'd0, digit, symbol}, {21'd0, 4'b1110, 7'b0000001});

        // Vector table: load, await commit, inspect the dead and lit cycles of one slot
        foreach (vecs[k]) begin
            lz_blank = vecs[k].lz;
            do_load(vecs[k].v, vecs[k].d);
            wait_frame();
            tick(4 * vecs[k].slot + 1);
            chk("vec_dead_digit", {28'd0, digit}, {28'd0, 4'b1111});
            tick(1);
            chk($sformatf("vec%0d", k), {20'd0, digit, symbol, dp},
                {20'd0, vecs[k].dig, vecs[k].sym, vecs[k].dpo});
        end
        lz_blank = 1'b0;

        // Mid-frame load must not tear the frame in progress
        do_load(16'h2222, 4'b0000);
        wait_frame();
        tick(5);
        do_load(16'h0001, 4'b0000);
        tick(4);
        chk("midload_slot2", {21'd0, digit, symbol}, {21'd0, 4'b1011, 7'b0010010});
        tick(4);
        chk("midload_slot3", {21'd0, digit, symbol}, {21'd0, 4'b0111, 7'b0010010});
        wait_frame();
        tick(2);
        chk("midload_commit", {21'd0, digit, symbol}, {21'd0, 4'b1110, 7'b1001111});

        // Load in the boundary cycle wins over an older pending value
        wait_frame();
        tick(3);
        do_load(16'h0007, 4'b0000);
        tick(11);
        do_load(16'h0005, 4'b0000);
        chk("collide_frame", {31'd0, frame}, 32'd1);
        tick(2);
        chk("collide_slot0", {25'd0, symbol}, {25'd0, 7'b0100100});
        tick(FRAME);
        chk("collide_stable", {25'd0, symbol}, {25'd0, 7'b0100100});

        // Dark display keeps scanning and still captures loads
        wait_frame();
        enable = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            if (i == 3) begin value = 16'h0009; dp_in = 4'b0000; load = 1'b1; end
            if (i == 4) load = 1'b0;
            tick(1);
            chk("dark_outputs", {21'd0, digit, symbol}, {21'd0, 4'b1111, 7'b1111111});
            if (i == FRAME) chk("dark_frame", {31'd0, frame}, 32'd1);
        end
        enable = 1'b1;
        wait_frame();
        tick(2);
        chk("dark_release", {21'd0, digit, symbol}, {21'd0, 4'b1110, 7'b0000100});

        // Random traffic, checked cycle by cycle against the model
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom % 400) == 0;
            load   = ($urandom % 10) == 0;
            value  = 16'($urandom) >> (4 * $urandom_range(0, 4));
            dp_in  = 4'($urandom);
            enable = ($urandom % 20) != 0;
            if (($urandom % 40) == 0) lz_blank = ~lz_blank;
            tick(1);
        end
        rst = 1'b0; load = 1'b0; enable = 1'b1;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
